// File: rtl/ofdm_symbol_scheduler.sv
// ofdm_symbol_scheduler
// Sits between the QAM mapper and IFFT64. Collects 48 mapped data symbols,
// then streams one 64-bin frequency-domain frame (data, pilots, nulls) as a
// contiguous out_en burst, followed by an idle gap of GAP_CYC cycles so the
// IFFT pipeline can drain before the next symbol starts.
// Optional build macro PILOT_SCRAMBLE_EN: per-symbol pilot polarity taken
// from a 7-bit LFSR (x^7+x^4+1, seed 7'h7F); without it pilots are fixed.
//
// state | meaning
// FILL  | accepting mapper samples into the 48-entry buffer
// EMIT  | streaming bins 0..63 with out_en high
// GAP   | idle for GAP_CYC cycles, then back to FILL
module ofdm_symbol_scheduler #(
    parameter int                       DATA_W    = 16,
    parameter logic signed [DATA_W-1:0] PILOT_AMP = 16'sd8192,
    parameter int                       GAP_CYC   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    output logic              out_en,
    output logic [DATA_W-1:0] out_x,
    output logic [DATA_W-1:0] out_y,
    output logic [5:0]        out_idx,
    output logic              sym_start,
    output logic              busy,
    output logic [15:0]       sym_count
);

    typedef enum logic [1:0] {ST_FILL, ST_EMIT, ST_GAP} state_t;

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);
    localparam logic signed [DATA_W-1:0] AMP_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] AMP_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    // Saturate so a full-scale negative PILOT_AMP cannot wrap when negated.
    localparam logic signed [DATA_W-1:0] PILOT_NEG = (PILOT_AMP == AMP_MIN) ? AMP_MAX : -PILOT_AMP;

    state_t              state, state_nxt;
    logic [5:0]          fill_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [2*DATA_W-1:0] sample_buf [48];
    logic                accept, wr_en, fill_done, emit_last, gap_done, emit_load;
    logic [5:0]          bin_nxt, entry;
    logic                is_data, pilot_flip;
    logic [DATA_W-1:0]   x_nxt, y_nxt;

    assign accept    = in_valid && in_ready;
    assign wr_en     = (state == ST_FILL) && accept && !flush;
    assign fill_done = wr_en && (fill_cnt == 6'd47);
    assign emit_last = (state == ST_EMIT) && (out_idx == 6'd63);
    assign gap_done  = (state == ST_GAP) && (gap_cnt == '0);
    // Outputs are loaded one edge ahead: bin 0 on the 48th accept, then every EMIT cycle but the last.
    assign emit_load = fill_done || ((state == ST_EMIT) && !emit_last);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_FILL;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FILL: if (fill_done) state_nxt = ST_EMIT;
            ST_EMIT: if (emit_last) state_nxt = ST_GAP;
            ST_GAP:  if (gap_done)  state_nxt = ST_FILL;
            default: state_nxt = ST_FILL;
        endcase
    end

    // State-decoded outputs; in_ready is held low for the whole reset assertion
    always_comb begin
        in_ready = (state == ST_FILL) && !reset;
        busy     = (state == ST_EMIT) || (state == ST_GAP);
    end

    // Fill pointer: flush wins over a coincident accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_cnt <= '0;
        end else if (state == ST_FILL) begin
            if (flush)       fill_cnt <= '0;
            else if (accept) fill_cnt <= fill_cnt + 6'd1;
        end else if (emit_last) begin
            fill_cnt <= '0;
        end
    end

    // Sample storage; contents are only meaningful up to fill_cnt, so no reset
    always_ff @(posedge clk) begin
        if (wr_en) sample_buf[fill_cnt] <= {in_x, in_y};
    end

    // Gap timer: down-counter, terminal count at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                            gap_cnt <= '0;
        else if (emit_last)                   gap_cnt <= GAP_LOAD;
        else if (state == ST_GAP && !gap_done) gap_cnt <= gap_cnt - 1'b1;
    end

`ifdef PILOT_SCRAMBLE_EN
    logic [6:0] lfsr;

    // Pilot polarity LFSR, advanced once per symbol on its last bin
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          lfsr <= 7'h7F;
        else if (emit_last) lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[3]};
    end

    assign pilot_flip = lfsr[6] ^ lfsr[3];
`else
    assign pilot_flip = 1'b0;
`endif

    // Bin map for the next output sample: data bins read buffer entries in order
    always_comb begin
        bin_nxt = (state == ST_EMIT) ? out_idx + 6'd1 : 6'd0;
        entry   = '0;
        is_data = 1'b1;
        if      (bin_nxt >= 6'd1  && bin_nxt <= 6'd6)  entry = bin_nxt - 6'd1;
        else if (bin_nxt >= 6'd8  && bin_nxt <= 6'd20) entry = bin_nxt - 6'd2;
        else if (bin_nxt >= 6'd22 && bin_nxt <= 6'd26) entry = bin_nxt - 6'd3;
        else if (bin_nxt >= 6'd38 && bin_nxt <= 6'd42) entry = bin_nxt - 6'd14;
        else if (bin_nxt >= 6'd44 && bin_nxt <= 6'd56) entry = bin_nxt - 6'd15;
        else if (bin_nxt >= 6'd58)                      entry = bin_nxt - 6'd16;
        else                                            is_data = 1'b0;

        x_nxt = '0;
        y_nxt = '0;
        if (is_data)
            {x_nxt, y_nxt} = sample_buf[entry];
        else if (bin_nxt == 6'd7 || bin_nxt == 6'd21 || bin_nxt == 6'd43)
            x_nxt = pilot_flip ? PILOT_NEG : PILOT_AMP;
        else if (bin_nxt == 6'd57)
            x_nxt = pilot_flip ? PILOT_AMP : PILOT_NEG;
    end

    // Registered frame outputs; zeroed whenever no burst sample is being driven
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_en    <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_idx   <= '0;
            sym_start <= 1'b0;
        end else if (emit_load) begin
            out_en    <= 1'b1;
            out_x     <= x_nxt;
            out_y     <= y_nxt;
            out_idx   <= bin_nxt;
            sym_start <= (bin_nxt == 6'd0);
        end else begin
            out_en    <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_idx   <= '0;
            sym_start <= 1'b0;
        end
    end

    // Completed-symbol counter, wraps naturally at 16 bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          sym_count <= '0;
        else if (emit_last) sym_count <= sym_count + 16'd1;
    end

endmodule

// File: doc/ofdm_symbol_scheduler.md
Name: ofdm_symbol_scheduler

Overview:
Sequences the transmit datapath between the QAM mapper and IFFT64. Buffers 48 mapped data symbols, then emits one 64-bin frequency-domain frame with data, pilot and null subcarriers. The frame is a contiguous 64-cycle di_en burst into IFFT64. A programmable idle gap follows each burst so the IFFT pipeline drains before the next symbol starts.

Parameters:
DATA_W, 16, width of signed I/Q samples
PILOT_AMP, 16'sd8192, pilot magnitude (real part; imaginary part is 0)
GAP_CYC, 64, idle cycles forced after each burst (minimum 1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous; discards the partially filled buffer
in_valid  in  1  mapper sample valid
in_ready  out  1  scheduler can accept a sample
in_x  in  DATA_W  mapper I (signed)
in_y  in  DATA_W  mapper Q (signed)
out_en  out  1  frame sample valid; drives IFFT64 di_en
out_x  out  DATA_W  frame I; drives di_re
out_y  out  DATA_W  frame Q; drives di_im
out_idx  out  6  subcarrier bin of the current output sample
sym_start  out  1  one-cycle pulse coincident with out_idx==0 and out_en
busy  out  1  high in EMIT or GAP
sym_count  out  16  count of completed symbols

Behaviour:
- Reset values: out_en=0, out_x=0, out_y=0, out_idx=0, sym_start=0, busy=0, sym_count=0, fill count=0, state=FILL. in_ready is forced 0 while reset is asserted.
- FSM states are FILL, EMIT and GAP.
- FILL:
  - in_ready=1.
  - An accept is in_valid and in_ready on the same edge. Each accept writes {in_x,in_y} to buffer entry fill_cnt, then fill_cnt increments.
  - The 48th accept (fill_cnt 47 to 48) moves the FSM to EMIT on the same edge. The first out_en is on the next cycle.
- EMIT:
  - in_ready=0.
  - Runs exactly 64 consecutive cycles with out_en=1 and out_idx counting 0 to 63. Outputs are registered.
  - Null bins 0 and 27..37: out_x=out_y=0.
  - Pilot bins 7, 21, 43, 57: out_x=±PILOT_AMP, out_y=0.
  - Data bins, in ascending bin order, read buffer entries 0..47:
    - bins 1-6 read entries 0-5
    - bins 8-20 read entries 6-18
    - bins 22-26 read entries 19-23
    - bins 38-42 read entries 24-28
    - bins 44-56 read entries 29-41
    - bins 58-63 read entries 42-47
  - On the cycle with out_idx==63, sym_count increments (wraps 65535 to 0) and fill_cnt clears. The next state is GAP.
- GAP:
  - in_ready=0, out_en=0, out_x=out_y=0.
  - Lasts exactly GAP_CYC cycles, then returns to FILL.
- Timing: the first out_en=1 for symbol n+1 occurs no earlier than GAP_CYC+1 cycles after the last out_en of symbol n.
- flush:
  - In FILL: clears fill_cnt. If flush and an accept coincide, flush wins and the sample is dropped.
  - In EMIT or GAP: ignored. The burst always completes as 64 cycles.
- Asynchronous reset mid-EMIT aborts immediately: out_en drops to 0 with no partial-burst completion.
- busy = (state==EMIT or state==GAP).

Optional Feature:
Macro PILOT_SCRAMBLE_EN.
- Without it: pilot polarity is fixed at bins 7/21/43 = +PILOT_AMP and bin 57 = -PILOT_AMP.
- With it: the fixed pattern is multiplied by p, which is constant for the whole symbol.
  - p comes from a 7-bit LFSR, polynomial x^7+x^4+1, seeded 7'h7F at reset.
  - p=+1 when lfsr[6]^lfsr[3]==0, else -1.
  - The LFSR shifts left, inserting lfsr[6]^lfsr[3], on the out_idx==63 cycle.
  - First symbol: p=+1.
  - Negating PILOT_AMP must not overflow.

Test Plan:
1. Reset; 48 back-to-back accepts with in_x=j, in_y=-j (j=0..47) -> out_en high 64 cycles, starting the cycle after the 48th accept. Bin 1 = (0,0); bin 8 = (6,-6); bin 38 = (24,-24); bin 63 = (47,-47). Bins 0 and 27..37 = (0,0). Bin 7 = (8192,0); bin 57 = (-8192,0). sym_start coincides with idx 0. sym_count=1 after the burst.
2. in_valid held high throughout two symbols -> in_ready=0 for exactly 64+GAP_CYC cycles after each 48th accept. No samples are lost or duplicated: second symbol bin 1 = the 49th input.
3. 20 accepts, then flush, then 48 accepts of value 100+j -> burst bin 1 = (100,-100). No pre-flush data appears. flush asserted during EMIT -> burst still 64 cycles.
4. Assert reset at out_idx=30 -> out_en=0 and sym_count=0 immediately, without waiting for a clock edge. After release, a fresh 48-sample fill produces a normal burst.
5. Preload sym_count near wrap via 65536 symbols (or force) -> 65535 wraps to 0. GAP length measured exactly GAP_CYC with GAP_CYC=1 and 64.
6. With PILOT_SCRAMBLE_EN: 8 symbols -> bin-7 polarity follows the LFSR p sequence starting +1. Without it: bin-7 polarity is +8192 on every symbol.
